// File: rtl/aes_pkg.sv
// aes_pkg: shared AES widths, loader state encoding and byte-lane helper
package aes_pkg;
    localparam int AES_BITS  = 128;
    localparam int AES_BYTES = 16;

    typedef enum logic [1:0] {IDLE, KEY, DATA, HOLD} state_t;

    // Byte i of a section occupies bits [8i : 8i+7] of a [0:127] word.
    // The byte's MSB lands on the lowest bit index.
    function automatic logic [0:AES_BITS-1] put_lane(
        input logic [0:AES_BITS-1] v,
        input logic [3:0]          i,
        input logic [7:0]          b
    );
        v[{i, 3'b000} +: 8] = b;
        return v;
    endfunction
endpackage

// File: rtl/aes_block_loader_if.sv
// aes_block_loader_if: byte-stream input and key/block output handshakes of the loader
//   in_byte/in_valid/in_ready, load_key, abort : byte stream from the feeder
//   key_out/block_out/out_valid/out_ready       : block presented to the AES core
//   err, key_loaded                             : status
interface aes_block_loader_if;
    import aes_pkg::*;
    logic [7:0]          in_byte;
    logic                in_valid;
    logic                in_ready;
    logic                load_key;
    logic                abort;
    logic [0:AES_BITS-1] key_out;
    logic [0:AES_BITS-1] block_out;
    logic                out_valid;
    logic                out_ready;
    logic                err;
    logic                key_loaded;

    modport master (
        output in_byte, in_valid, load_key, abort, out_ready,
        input  in_ready, key_out, block_out, out_valid, err, key_loaded
    );
    modport slave (
        input  in_byte, in_valid, load_key, abort, out_ready,
        output in_ready, key_out, block_out, out_valid, err, key_loaded
    );
endinterface

// File: rtl/aes_byte_shift_reg.sv
// aes_byte_shift_reg: 16-byte staging register written one byte lane at a time
//   clk, rst_n : clock, async active-low reset (clears the register)
//   we, idx    : write enable and byte-lane index (0..15)
//   din        : byte written into lane idx
//   q          : staged word in [0:127] big-endian bit order
module aes_byte_shift_reg
    import aes_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [3:0]          idx,
    input  logic [7:0]          din,
    output logic [0:AES_BITS-1] q
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            q <= '0;
        else if (we)
            q <= put_lane(q, idx, din);
endmodule

// File: rtl/aes_block_loader.sv
// aes_block_loader: assembles key/plaintext frames from a byte stream for the AES core
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of aes_block_loader_if (stream in, block out, err, key_loaded)
module aes_block_loader
    import aes_pkg::*;
#(
    parameter int NBYTES  = 16,
    parameter int TIMEOUT = 1024,
    parameter int TW      = 11
) (
    input logic              clk,
    input logic              rst_n,
    aes_block_loader_if.slave bus
);
    state_t              state, state_n;
    logic [3:0]          cnt, cnt_n;
    logic [TW-1:0]       idle_cnt, idle_n;
    logic                has_key, has_key_n;
    logic                key_we, data_we, fire, drop_err;
    logic                acc, last;
    logic [0:AES_BITS-1] key_q, data_q;

    assign bus.in_ready = rst_n && state != HOLD;
    assign acc          = bus.in_valid && bus.in_ready;
    assign last         = cnt == 4'(NBYTES - 1);

    // cnt is always 0 in IDLE, so the first byte of a frame lands in lane 0.
    aes_byte_shift_reg u_key (
        .clk(clk), .rst_n(rst_n), .we(key_we), .idx(cnt), .din(bus.in_byte), .q(key_q)
    );
    aes_byte_shift_reg u_data (
        .clk(clk), .rst_n(rst_n), .we(data_we), .idx(cnt), .din(bus.in_byte), .q(data_q)
    );

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        idle_n    = '0;
        has_key_n = has_key;
        key_we    = 1'b0;
        data_we   = 1'b0;
        fire      = 1'b0;
        drop_err  = 1'b0;
        case (state)
            IDLE: if (acc) begin
                state_n   = bus.load_key ? KEY : DATA;
                cnt_n     = 4'd1;
                has_key_n = bus.load_key;
                key_we    = bus.load_key;
                data_we   = !bus.load_key;
            end
            KEY, DATA: if (bus.abort) begin
                // abort wins over a byte accepted in the same cycle
                state_n = IDLE;
                cnt_n   = '0;
            end else if (acc) begin
                cnt_n   = cnt + 4'd1;
                key_we  = state == KEY;
                data_we = state == DATA;
                if (last && state == KEY)
                    state_n = DATA;
                else if (last) begin
                    // a data-only frame needs a previously stored key
                    fire     = has_key || bus.key_loaded;
                    drop_err = !fire;
                    state_n  = fire ? HOLD : IDLE;
                end
            end else if (TIMEOUT != 0 && idle_cnt == TW'(TIMEOUT - 1)) begin
                state_n  = IDLE;
                cnt_n    = '0;
                drop_err = 1'b1;
            end else
                idle_n = idle_cnt + 1'b1;
            HOLD: if (bus.out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            idle_cnt       <= '0;
            has_key        <= 1'b0;
            bus.key_out    <= '0;
            bus.block_out  <= '0;
            bus.out_valid  <= 1'b0;
            bus.err        <= 1'b0;
            bus.key_loaded <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            idle_cnt      <= idle_n;
            has_key       <= has_key_n;
            bus.err       <= drop_err;
            bus.out_valid <= state_n == HOLD;
            if (fire) begin
                // the final byte is not yet in data staging, merge it here
                bus.block_out <= put_lane(data_q, cnt, bus.in_byte);
                if (has_key) begin
                    bus.key_out    <= key_q;
                    bus.key_loaded <= 1'b1;
                end
            end
        end
endmodule

// File: tb/tb_aes_block_loader.sv
// tb_aes_block_loader: table vectors, corner sequences and randomized model check of aes_block_loader
module tb_aes_block_loader;
    import aes_pkg::*;

    typedef struct {
        logic         lk;
        logic [7:0]   base;
        logic [127:0] key;
        logic [127:0] blk;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    logic mon_en = 1'b0;
    int   err_seen = 0;
    logic [255:0] exp_q[$];

    aes_block_loader_if bus();

    aes_block_loader #(.NBYTES(16), .TIMEOUT(8), .TW(11)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // first byte ends up in the most significant (lowest-index) lane
    function automatic logic [127:0] pack(input logic [7:0] b[16]);
        logic [127:0] r;
        r = '0;
        foreach (b[i]) r = {r[119:0], b[i]};
        return r;
    endfunction

    function automatic logic [127:0] ramp(input logic [7:0] base);
        logic [7:0] b[16];
        foreach (b[i]) b[i] = base + 8'(i);
        return pack(b);
    endfunction

    task automatic idle_inputs;
        bus.in_valid = 1'b0;
        bus.load_key = 1'b0;
        bus.abort    = 1'b0;
        bus.in_byte  = 8'h00;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        bus.out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // back-to-back bytes base, base+1, ...; returns at the negedge after the last accept
    task automatic send_seq(input logic lk, input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.load_key = lk;
            bus.in_byte  = base + 8'(i);
            chk("send_in_ready", bus.in_ready, 1);
            chk("send_no_valid", bus.out_valid, 0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // one byte with random gaps, random out_ready, bounded wait for acceptance
    task automatic send_rand(input logic lk, input logic [7:0] b);
        int   gap = 0;
        int   guard = 0;
        logic done = 1'b0;
        while (!done) begin
            @(negedge clk);
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.load_key  = lk;
            bus.in_byte   = b;
            bus.in_valid  = !(gap < 2 && $urandom_range(0, 3) == 0);
            gap  = bus.in_valid ? 0 : gap + 1;
            done = bus.in_valid && bus.in_ready;
            guard++;
            if (!done && guard > 500) begin
                n_chk++;
                n_fail++;
                $display("FAIL rand_accept: byte %h not accepted within 500 cycles", b);
                done = 1'b1;
            end
        end
    endtask

    // handshake monitor for the randomized phase
    initial forever begin
        logic [255:0] e;
        @(negedge clk);
        #1;
        if (mon_en) begin
            if (bus.err) err_seen++;
            chk("err_with_valid", bus.err && bus.out_valid, 0);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL rand_extra: unexpected block %h", bus.block_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("rand_key", bus.key_out, e[255:128]);
                    chk("rand_blk", bus.block_out, e[127:0]);
                end
            end
        end
    end

    initial begin
        vec_t         tbl[4];
        logic         lk, model_loaded;
        int           nb, cut, exp_err;
        logic [7:0]   kb[16], db[16], b;
        logic [127:0] mkey;

        tbl[0] = '{1'b1, 8'h00, 128'h000102030405060708090a0b0c0d0e0f, 128'h101112131415161718191a1b1c1d1e1f};
        tbl[1] = '{1'b0, 8'hf0, 128'h000102030405060708090a0b0c0d0e0f, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff};
        tbl[2] = '{1'b1, 8'h40, 128'h404142434445464748494a4b4c4d4e4f, 128'h505152535455565758595a5b5c5d5e5f};
        tbl[3] = '{1'b0, 8'h80, 128'h404142434445464748494a4b4c4d4e4f, 128'h808182838485868788898a8b8c8d8e8f};

        idle_inputs();
        bus.out_ready = 1'b1;

        // reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_key_loaded", bus.key_loaded, 0);
        chk("rst_key_out", bus.key_out, 0);
        chk("rst_block_out", bus.block_out, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1);

        // data-only frame with no stored key
        send_seq(1'b0, 8'h20, 16);
        chk("nokey_err", bus.err, 1);
        chk("nokey_valid", bus.out_valid, 0);
        chk("nokey_key_loaded", bus.key_loaded, 0);
        @(negedge clk);
        chk("nokey_err_pulse", bus.err, 0);
        chk("nokey_valid2", bus.out_valid, 0);
        chk("nokey_in_ready", bus.in_ready, 1);

        // table-driven frames
        do_reset();
        foreach (tbl[k]) begin
            send_seq(tbl[k].lk, tbl[k].base, tbl[k].lk ? 32 : 16);
            chk($sformatf("tbl%0d_valid", k), bus.out_valid, 1);
            chk($sformatf("tbl%0d_key", k), bus.key_out, tbl[k].key);
            chk($sformatf("tbl%0d_blk", k), bus.block_out, tbl[k].blk);
            chk($sformatf("tbl%0d_err", k), bus.err, 0);
            chk($sformatf("tbl%0d_key_loaded", k), bus.key_loaded, 1);
            chk($sformatf("tbl%0d_in_ready_hold", k), bus.in_ready, 0);
            @(negedge clk);
            chk($sformatf("tbl%0d_valid_drop", k), bus.out_valid, 0);
            chk($sformatf("tbl%0d_in_ready", k), bus.in_ready, 1);
            chk($sformatf("tbl%0d_err_after", k), bus.err, 0);
        end

        // backpressure: held block with in_valid high
        bus.out_ready = 1'b0;
        send_seq(1'b1, 8'ha0, 32);
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'h55;
        bus.load_key = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("hold_in_ready", bus.in_ready, 0);
            chk("hold_valid", bus.out_valid, 1);
            chk("hold_key", bus.key_out, ramp(8'ha0));
            chk("hold_blk", bus.block_out, ramp(8'hb0));
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("release_valid", bus.out_valid, 0);
        chk("release_in_ready", bus.in_ready, 1);
        bus.in_valid = 1'b0;

        // timeout after 5 key bytes
        send_seq(1'b1, 8'h11, 5);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("timeout_early_err", bus.err, 0);
        end
        @(negedge clk);
        chk("timeout_err", bus.err, 1);
        chk("timeout_key_kept", bus.key_out, ramp(8'ha0));
        chk("timeout_key_loaded", bus.key_loaded, 1);
        @(negedge clk);
        chk("timeout_err_pulse", bus.err, 0);
        chk("timeout_in_ready", bus.in_ready, 1);
        send_seq(1'b0, 8'hc0, 16);
        chk("after_timeout_valid", bus.out_valid, 1);
        chk("after_timeout_key", bus.key_out, ramp(8'ha0));
        chk("after_timeout_blk", bus.block_out, ramp(8'hc0));
        @(negedge clk);

        // abort after 5 key bytes, with a byte offered in the abort cycle
        send_seq(1'b1, 8'h22, 5);
        bus.abort    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_byte  = 8'h99;
        @(negedge clk);
        bus.abort    = 1'b0;
        bus.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("abort_no_err", bus.err, 0);
            @(negedge clk);
        end
        send_seq(1'b0, 8'hd0, 16);
        chk("after_abort_valid", bus.out_valid, 1);
        chk("after_abort_key", bus.key_out, ramp(8'ha0));
        chk("after_abort_blk", bus.block_out, ramp(8'hd0));
        @(negedge clk);

        // reset pulse mid-DATA
        send_seq(1'b1, 8'h60, 20);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", bus.out_valid, 0);
        chk("midrst_err", bus.err, 0);
        chk("midrst_key_loaded", bus.key_loaded, 0);
        chk("midrst_key", bus.key_out, 0);
        chk("midrst_blk", bus.block_out, 0);
        chk("midrst_in_ready", bus.in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send_seq(1'b1, 8'h70, 32);
        chk("postrst_valid", bus.out_valid, 1);
        chk("postrst_key", bus.key_out, ramp(8'h70));
        chk("postrst_blk", bus.block_out, ramp(8'h80));
        chk("postrst_key_loaded", bus.key_loaded, 1);
        @(negedge clk);

        // randomized frames against a frame-level model
        do_reset();
        model_loaded = 1'b0;
        mkey = '0;
        exp_err = 0;
        mon_en = 1'b1;
        for (int f = 0; f < 40; f++) begin
            lk  = $urandom_range(0, 2) == 0;
            nb  = lk ? 32 : 16;
            cut = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, nb - 1)) : nb;
            foreach (kb[i]) begin
                kb[i] = 8'($urandom);
                db[i] = 8'($urandom);
            end
            if (cut == nb) begin
                if (lk) begin
                    mkey = pack(kb);
                    model_loaded = 1'b1;
                end
                if (model_loaded) exp_q.push_back({mkey, pack(db)});
                else exp_err++;
            end
            for (int i = 0; i < cut; i++) begin
                if (lk && i < 16) b = kb[i];
                else if (lk) b = db[i - 16];
                else b = db[i];
                send_rand(i == 0 ? lk : 1'($urandom), b);
            end
            if (cut < nb) begin
                @(negedge clk);
                bus.abort    = 1'b1;
                bus.in_valid = 1'($urandom);
                bus.in_byte  = 8'($urandom);
                @(negedge clk);
                bus.abort    = 1'b0;
                bus.in_valid = 1'b0;
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int g = 0; g < 200 && exp_q.size() != 0; g++) begin
            @(negedge clk);
            bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        mon_en = 1'b0;
        chk("rand_queue_empty", exp_q.size(), 0);
        chk("rand_err_count", err_seen, exp_err);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_block_loader.md
Name: aes_block_loader

Overview:
- Upstream feeder for the AES core `top`. Accepts a byte stream over a valid/ready handshake and assembles 128-bit key and plaintext words in the core's [0:127] big-endian bit ordering.
- Presents each completed block to the core over a second valid/ready handshake.
- Stores the last loaded key so that later frames can carry plaintext only.

Parameters:
- NBYTES, 16, bytes per key and per block; fixed at 16 for AES-128, other values unsupported.
- TIMEOUT, 1024, idle cycles allowed mid-frame before the partial frame is dropped; 0 disables the timeout.
- TW, 11, timeout counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_byte  in  8  stream byte.
- in_valid  in  1  in_byte is valid.
- in_ready  out  1  loader accepts a byte this cycle.
- load_key  in  1  frame type; sampled only on the first accepted byte of a frame.
- abort  in  1  synchronous discard of the partial frame.
- key_out  out  [0:127]  key for the presented block.
- block_out  out  [0:127]  plaintext block.
- out_valid  out  1  key_out and block_out are presented.
- out_ready  in  1  core consumes the presented block.
- err  out  1  one-cycle pulse on a dropped frame.
- key_loaded  out  1  a key has been stored since reset.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; all counters 0.
  - key_out, block_out and the key/data staging registers = 0.
  - out_valid=0, err=0, key_loaded=0.
  - in_ready forced low while rst_n is low.
- States: IDLE, KEY, DATA, HOLD.
- in_ready = rst_n && state!=HOLD. This is a combinational decode of registered state.
- A byte is accepted when in_valid && in_ready.
- Byte ordering: the byte with index i (0..15) of a section goes to bits [8i : 8i+7]. The first byte lands in [0:7].
- IDLE, on an accepted byte:
  - load_key=1: byte goes to key staging index 0; cnt=1; go to KEY.
  - load_key=0: byte goes to data staging index 0; cnt=1; go to DATA. The nokey flag is latched as !key_loaded.
- KEY:
  - Each accept writes key staging[cnt] and increments cnt.
  - When byte 15 is accepted: cnt=0; go to DATA; the nokey flag is cleared.
- DATA:
  - Each accept writes data staging[cnt].
  - On accepting byte 15, when the frame had a key section or key_loaded=1:
    - block_out <= data staging with the final byte merged in.
    - If the frame carried a key, key_out <= key staging and key_loaded <= 1. Otherwise key_out is unchanged.
    - out_valid <= 1; go to HOLD.
  - On accepting byte 15 with nokey set: err pulses for 1 cycle; no out_valid; return to IDLE.
- Latency: the last byte is accepted at edge N; out_valid is high from edge N onward. No bypass path.
- HOLD:
  - out_valid=1; key_out and block_out are stable.
  - When out_ready is high at an edge, out_valid <= 0 and state <= IDLE. in_ready is high the following cycle.
  - While out_ready stays low, HOLD is held indefinitely (backpressure).
- Timeout:
  - In KEY/DATA, idle_cnt increments on each cycle with no accepted byte and clears on an accept.
  - When idle_cnt reaches TIMEOUT, the partial frame is dropped: err pulses; state <= IDLE; cnt=0.
  - Stored key_out and key_loaded are untouched because the staging register is separate.
- abort:
  - Sampled high in KEY/DATA: same as timeout but with no err pulse.
  - Ignored in IDLE and HOLD; a presented block is never retracted.
  - abort has priority over a byte accepted in the same cycle; that byte is discarded.
- A frame with load_key=1 replaces the stored key only on successful completion of the frame.
- err is never asserted together with out_valid rising.

Decomposition:
- Shared package aes_pkg:
  - Block width constant AES_BITS=128 and AES_BYTES=16.
  - State encoding for IDLE/KEY/DATA/HOLD.
  - Byte-lane slice helper (index i to bit range [8i : 8i+7]).
- One natural sub-module: aes_byte_shift_reg. It is a 16-byte lane writer with write-enable and index. It is instantiated twice, once for key staging and once for data staging.
- The FSM, timeout counter and output registers stay in aes_block_loader.

Test Plan:
1. Reset, then a 32-byte frame with load_key=1, bytes 0x00..0x1F, out_ready=1:
   - key_out=000102..0F and block_out=101112..1F.
   - out_valid for 1 cycle, rising at the edge of the 32nd accept.
   - key_loaded=1.
2. After test 1, a 16-byte frame with load_key=0, bytes 0xF0..0xFF:
   - block_out=F0..FF and key_out unchanged (00..0F).
   - No err.
3. Straight after reset, a 16-byte frame with load_key=0:
   - err pulses 1 cycle after the 16th byte.
   - out_valid stays 0 and key_loaded stays 0.
4. Complete frame with out_ready=0 for 50 cycles while in_valid=1:
   - in_ready=0 and outputs stable throughout.
   - out_ready=1 then gives out_valid=0 next cycle, and in_ready=1 in that same cycle.
5. TIMEOUT=8; send 5 key bytes, then idle 8 cycles:
   - err pulse; state back to IDLE; the previous key_out is retained.
   - A repeat of the same scenario using abort instead of idle gives no err.
6. Assert rst_n low mid-DATA for 1 cycle:
   - out_valid, err, key_loaded, key_out and block_out all become 0 immediately.
   - The next full frame completes normally.
